// File: rtl/sig_phase_gen.sv
// sig_phase_gen: phase-accumulator address generator for the sine lookup ROM.
// The accumulator advances by cur_step each running cycle. Its integer part is
// the ROM address. A second, registered offset drives the ROM's other port.
// New steps are applied at once or glided toward, one increment per overflow.
module sig_phase_gen #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int FRAC_WIDTH    = 8,
    parameter int GLIDE_STEP    = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic                                  sweep_en,
    input  logic                                  step_valid,
    output logic                                  step_ready,
    input  logic [ADDRESS_WIDTH+FRAC_WIDTH-1:0]   step_in,
    input  logic [ADDRESS_WIDTH-1:0]              offset_in,
    output logic [ADDRESS_WIDTH-1:0]              addr,
    output logic [ADDRESS_WIDTH-1:0]              offset,
    output logic                                  wrap,
    output logic                                  busy
);

    localparam int              PW        = ADDRESS_WIDTH + FRAC_WIDTH;
    localparam logic [PW-1:0]   UNIT_STEP = PW'(1) << FRAC_WIDTH;
    localparam logic [PW-1:0]   GLIDE_INC = PW'(GLIDE_STEP);

    typedef enum logic [1:0] {IDLE, RUN, GLIDE} state_t;

    state_t                     r_state;
    state_t                     w_stateNext;
    logic [PW-1:0]              r_acc;
    logic [PW-1:0]              r_curStep;
    logic [PW-1:0]              r_target;
    logic [ADDRESS_WIDTH-1:0]   r_offset;
    logic                       r_wrap;

    logic [PW:0]                w_sum;
    logic                       w_carry;
    logic                       w_running;
    logic                       w_accept;
    logic [PW-1:0]              w_diff;
    logic [PW-1:0]              w_glideNext;
    logic [PW-1:0]              w_curStepNext;
    logic [PW-1:0]              w_targetNext;

    assign w_sum      = {1'b0, r_acc} + {1'b0, r_curStep};
    assign w_carry    = w_sum[PW];
    assign w_running  = (r_state != IDLE);
    assign step_ready = ~rst & (r_state != GLIDE);
    assign w_accept   = step_valid & step_ready;

    assign addr   = r_acc[PW-1 -: ADDRESS_WIDTH];
    assign offset = r_offset;
    assign wrap   = r_wrap;
    assign busy   = (r_state == GLIDE);

    // One glide increment toward target, clamped so it lands exactly on target
    always_comb begin
        w_diff      = '0;
        w_glideNext = r_curStep;
        if (r_target > r_curStep) begin
            w_diff      = r_target - r_curStep;
            w_glideNext = (w_diff <= GLIDE_INC) ? r_target : r_curStep + GLIDE_INC;
        end else begin
            w_diff      = r_curStep - r_target;
            w_glideNext = (w_diff <= GLIDE_INC) ? r_target : r_curStep - GLIDE_INC;
        end
    end

    // Next state and next step/target; outside GLIDE target always equals cur_step,
    // so a sweep request arriving while en drops is treated as an immediate load
    always_comb begin
        w_stateNext   = r_state;
        w_curStepNext = r_curStep;
        w_targetNext  = r_target;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_curStepNext = step_in;
                    w_targetNext  = step_in;
                end
                if (en) w_stateNext = RUN;
            end
            RUN: begin
                if (w_accept) begin
                    if (sweep_en && en && (step_in != r_curStep)) begin
                        w_targetNext = step_in;
                        w_stateNext  = GLIDE;
                    end else begin
                        w_curStepNext = step_in;
                        w_targetNext  = step_in;
                    end
                end
                if (!en) w_stateNext = IDLE;
            end
            GLIDE: begin
                if (!en) begin
                    w_curStepNext = r_target;
                    w_stateNext   = IDLE;
                end else if (w_carry || (r_curStep == '0)) begin
                    w_curStepNext = w_glideNext;
                    if (w_glideNext == r_target) w_stateNext = RUN;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // State, accumulator, step registers, wrap pulse and period-aligned offset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_curStep <= UNIT_STEP;
            r_target  <= UNIT_STEP;
            r_offset  <= '0;
            r_wrap    <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_curStep <= w_curStepNext;
            r_target  <= w_targetNext;
            r_acc     <= w_running ? w_sum[PW-1:0] : r_acc;
            r_wrap    <= w_running & w_carry;
            if (!w_running || w_carry) r_offset <= offset_in;
        end
    end

endmodule
